// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit framer.
// Optional parity support is enabled by defining UART_TX_FRAMER_PARITY_EN.
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_FRAMER_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_t;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte-in / serial-out handshake bundle for the UART transmit framer.
interface uart_tx_framer_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] tx_data;
   logic                      tx_start;
   logic                      serial_out;
   logic                      tx_busy;
   logic                      tx_done;

   modport master (output tx_data, output tx_start,
                   input serial_out, input tx_busy, input tx_done);
   modport slave  (input tx_data, input tx_start,
                   output serial_out, output tx_busy, output tx_done);

endinterface

// File: rtl/tx_pts_sr.sv
// Parallel-load, shift-right register; LSB is always the next bit to send.
module tx_pts_sr
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             sout
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         sr <= '1;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= {UART_IDLE_LEVEL, sr[WIDTH-1:1]};
      end
   end

   assign sout = sr[0];

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_TX_FRAMER_PARITY_EN to insert the parity bit before stop.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic             clk,
   input  logic             n_rst,
   uart_tx_framer_if.slave  bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   tx_state_t     state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    idx, idx_nxt;
   logic          line, line_nxt;
   logic          done, done_nxt;
   logic          load, shift, sr_lsb, bit_end;

   tx_pts_sr #(.WIDTH(UART_DATA_BITS)) u_sr (
      .clk   (clk),
      .n_rst (n_rst),
      .load  (load),
      .shift (shift),
      .din   (bus.tx_data),
      .sout  (sr_lsb)
   );

`ifdef UART_TX_FRAMER_PARITY_EN
   logic par;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         par <= 1'b0;
      end else if (load) begin
         par <= ^bus.tx_data;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         line  <= UART_IDLE_LEVEL;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         line  <= line_nxt;
         done  <= done_nxt;
      end
   end

   assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

   // Line value is chosen one edge ahead so serial_out comes straight from a flop.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      line_nxt  = line;
      done_nxt  = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         IDLE: begin
            line_nxt = UART_IDLE_LEVEL;
            if (bus.tx_start) begin
               state_nxt = START;
               cnt_nxt   = '0;
               load      = 1'b1;
               line_nxt  = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               line_nxt  = sr_lsb;
               shift     = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (idx == 4'(UART_DATA_BITS - 1)) begin
                  idx_nxt = '0;
`ifdef UART_TX_FRAMER_PARITY_EN
                  state_nxt = PARITY;
                  line_nxt  = par;
`else
                  state_nxt = STOP;
                  line_nxt  = UART_IDLE_LEVEL;
`endif
               end else begin
                  idx_nxt  = idx + 1'b1;
                  line_nxt = sr_lsb;
                  shift    = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`ifdef UART_TX_FRAMER_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               cnt_nxt   = '0;
               line_nxt  = UART_IDLE_LEVEL;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               line_nxt  = UART_IDLE_LEVEL;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            line_nxt  = UART_IDLE_LEVEL;
         end
      endcase
   end

   assign bus.serial_out = line;
   assign bus.tx_busy    = (state != IDLE);
   assign bus.tx_done    = done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer (parity cases need UART_TX_FRAMER_PARITY_EN).
module tb_uart_tx_framer;

   localparam int C = 10;

   logic clk = 1'b0;
   logic n_rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   uart_tx_framer_if bus ();

   uart_tx_framer #(.CLKS_PER_BIT(C)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called right after the accepting edge; walks the whole frame cycle by cycle.
   // inj_t: cycle at which a (to be ignored) start with data FF is raised.
   // stop_t: cycle at which to return early without checking (for aborts).
   task automatic frame_check(input logic [7:0] d, input int inj_t, input int stop_t);
      logic [10:0] bits;
      int          nb;
`ifdef UART_TX_FRAMER_PARITY_EN
      bits = {1'b1, ^d, d, 1'b0};
      nb   = 11;
`else
      bits = {1'b0, 1'b1, d, 1'b0};
      nb   = 10;
`endif
      for (int t = 0; t < nb * C; t++) begin
         if (t == stop_t) return;
         check("line", 8'(bus.serial_out), 8'(bits[t / C]));
         check("busy", 8'(bus.tx_busy), 8'd1);
         check("done_low", 8'(bus.tx_done), 8'd0);
         if (t == inj_t) begin
            bus.tx_start = 1'b1;
            bus.tx_data  = 8'hFF;
         end else begin
            bus.tx_start = 1'b0;
         end
         tick();
      end
      check("done_pulse", 8'(bus.tx_done), 8'd1);
      check("busy_end", 8'(bus.tx_busy), 8'd0);
      check("line_end", 8'(bus.serial_out), 8'd1);
   endtask

   task automatic start_frame(input logic [7:0] d);
      bus.tx_data  = d;
      bus.tx_start = 1'b1;
      tick();
   endtask

   initial begin
      // Reset held with a pending start request
      n_rst        = 1'b0;
      bus.tx_start = 1'b1;
      bus.tx_data  = 8'hA5;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_line", 8'(bus.serial_out), 8'd1);
         check("rst_busy", 8'(bus.tx_busy), 8'd0);
         check("rst_done", 8'(bus.tx_done), 8'd0);
      end
      bus.tx_start = 1'b0;
      n_rst        = 1'b1;
      tick();
      check("idle_busy", 8'(bus.tx_busy), 8'd0);
      check("idle_line", 8'(bus.serial_out), 8'd1);

      // Single frame A5
      start_frame(8'hA5);
      frame_check(8'hA5, -1, -1);
      tick();
      check("done_once", 8'(bus.tx_done), 8'd0);

      // Back-to-back 00 then FF, second start during tx_done
      start_frame(8'h00);
      frame_check(8'h00, -1, -1);
      start_frame(8'hFF);
      frame_check(8'hFF, -1, -1);
      tick();

      // Start while busy is ignored, data change has no effect
      start_frame(8'h3C);
      frame_check(8'h3C, 35, -1);
      for (int i = 0; i < 15; i++) begin
         tick();
         check("no_queue_busy", 8'(bus.tx_busy), 8'd0);
         check("no_queue_line", 8'(bus.serial_out), 8'd1);
      end

      // Reset mid-frame, then a fresh frame right after release
      start_frame(8'h55);
      frame_check(8'h55, -1, 45);
      n_rst = 1'b0;
      tick();
      check("abort_line", 8'(bus.serial_out), 8'd1);
      check("abort_busy", 8'(bus.tx_busy), 8'd0);
      check("abort_done", 8'(bus.tx_done), 8'd0);
      n_rst = 1'b1;
      start_frame(8'h81);
      frame_check(8'h81, -1, -1);
      tick();

      // Parity-relevant vectors (odd and even population)
      start_frame(8'h07);
      frame_check(8'h07, -1, -1);
      tick();
      start_frame(8'h03);
      frame_check(8'h03, -1, -1);
      tick();
      check("final_idle", 8'(bus.tx_busy), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10, clock cycles per serial bit period; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-low.
REQ-004 tx_data  input  8  byte to transmit; sampled only when a start is accepted.
REQ-005 tx_start  input  1  request strobe; a start is accepted when tx_start=1 and the FSM is in IDLE.
REQ-006 serial_out  output  1  line output; idle/mark level 1.
REQ-007 tx_busy  output  1  high while a frame is in progress.
REQ-008 tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-009 Frame format SHALL be: start bit 0, 8 data bits LSB first, optional parity bit (REQ-022), stop bit 1.
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 Transitions SHALL be: IDLE->START on an accepted start; START->DATA after CLKS_PER_BIT cycles; DATA->PARITY (parity enabled) or STOP after the 8th bit period; PARITY->STOP after one bit period; STOP->IDLE after one bit period.
REQ-012 On an accepted start at edge k, tx_data SHALL be latched and serial_out SHALL be 0 from edge k through edge k+CLKS_PER_BIT; serial_out is registered, with no combinational path from any input.
REQ-013 Each bit SHALL be held on serial_out for exactly CLKS_PER_BIT cycles; total frame length 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-014 tx_busy SHALL be 1 in every state except IDLE.
REQ-015 tx_done SHALL be 1 for exactly one cycle: the first IDLE cycle after STOP completes.
REQ-016 tx_start while tx_busy=1 SHALL be ignored; there is no queuing, and the latched byte is unchanged.
REQ-017 tx_start in the cycle tx_done=1 SHALL be accepted, giving back-to-back frames with no idle bit between stop and the next start.
REQ-018 Changes on tx_data after acceptance SHALL NOT affect the frame in progress.
REQ-019 Counter widths: bit-period counter $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1 and wrapping; bit index counter 4 bits, counting 0..7.

Reset
REQ-020 With n_rst=0 at a rising edge, the block SHALL go to IDLE with serial_out=1, tx_busy=0, tx_done=0, counters=0, and data register=8'hFF.
REQ-021 Reset mid-frame SHALL abort the frame: no tx_done; the line returns to 1 at that edge; a start is accepted on the first edge after release.

Configuration
REQ-022 Macro UART_TX_FRAMER_PARITY_EN: when defined, the PARITY state is present and transmits even parity (^tx_data) for one bit period between the last data bit and stop.
REQ-023 When UART_TX_FRAMER_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent, and DATA goes directly to STOP.

Structure
REQ-024 Package uart_pkg SHALL hold the tx_state_t enum, UART_DATA_BITS=8, and UART_IDLE_LEVEL=1'b1.
REQ-025 Sub-module tx_pts_sr (parallel-load, shift-right, load/shift enables, LSB-first serial out, reset to all ones) SHALL hold the data bits; uart_tx_framer contains the FSM and timers.

Verification
REQ-026 Reset at power-on with tx_start=1, n_rst=0 for 2 cycles -> serial_out=1, tx_busy=0, tx_done=0 throughout.
REQ-027 tx_data=8'hA5, pulse tx_start -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done pulses exactly at cycle 100 after acceptance.
REQ-028 8'h00 then 8'hFF, second tx_start coincident with tx_done -> 200 contiguous cycles, no idle gap, two tx_done pulses.
REQ-029 tx_data=8'h3C accepted, then tx_start=1 with tx_data=8'hFF at cycle 35 -> frame still carries 8'h3C, and no second frame follows.
REQ-030 n_rst=0 at cycle 45 of a frame -> serial_out=1 on that edge, tx_busy=0, no tx_done; a new 8'h81 frame then transmits correctly.
REQ-031 With UART_TX_FRAMER_PARITY_EN, tx_data=8'h07 -> parity bit 1, frame 110 cycles; with 8'h03 -> parity bit 0.
